// File: rtl/hsid_pkg.sv
// Shared HSID definitions: default widths, band-streamer state encoding and
// the words-per-vector helper.
package hsid_pkg;

    localparam int HSID_WORD_WIDTH          = 32;
    localparam int HSID_DATA_WIDTH          = 16;
    localparam int HSID_FIFO_ADDR_WIDTH     = 2;
    localparam int HSID_HSP_BANDS_WIDTH     = 8;
    localparam int HSID_HSP_LIBRARY_WIDTH   = 8;
    localparam int HSID_STREAMER_ADDR_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CAPTURED = 3'd1,
        ST_LIBRARY  = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_DONE     = 3'd4
    } hsid_streamer_state_t;

    // Number of memory words needed to hold one vector of 'bands' bands.
    function automatic int unsigned hsid_words_per_vector(input int unsigned bands,
                                                          input int unsigned bands_per_word);
        return (bands + bands_per_word - 32'd1) / bands_per_word;
    endfunction

endpackage

// File: rtl/hsid_streamer_buf.sv
// Prefetch FIFO for the band streamer: holds {last, captured, word} entries,
// exposes the head combinationally and supports a synchronous flush.
module hsid_streamer_buf #(
    parameter int WIDTH      = 34,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // A push into a full buffer is allowed only when the head leaves in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != (ADDR_WIDTH + 1)'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    // Storage array; no reset needed because empty slots are never observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            count <= count + (ADDR_WIDTH + 1)'(do_push) - (ADDR_WIDTH + 1)'(do_pop);
        end
    end

endmodule

// File: rtl/hsid_band_streamer.sv
// Fetches the captured vector and then the reference library from word memory
// and streams them as packed band words tagged with last/captured.
module hsid_band_streamer
    import hsid_pkg::*;
#(
    parameter int WORD_WIDTH        = HSID_WORD_WIDTH,
    parameter int DATA_WIDTH        = HSID_DATA_WIDTH,
    parameter int ADDR_WIDTH        = HSID_STREAMER_ADDR_WIDTH,
    parameter int BUFFER_WIDTH      = HSID_FIFO_ADDR_WIDTH,
    parameter int HSP_BANDS_WIDTH   = HSID_HSP_BANDS_WIDTH,
    parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic [ADDR_WIDTH-1:0]        captured_addr_in,
    input  logic [ADDR_WIDTH-1:0]        library_addr_in,
    input  logic [HSP_BANDS_WIDTH-1:0]   hsp_bands_in,
    input  logic [HSP_LIBRARY_WIDTH-1:0] hsp_library_size_in,
    output logic                         mem_req,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic                         mem_gnt,
    input  logic                         mem_rvalid,
    input  logic [WORD_WIDTH-1:0]        mem_rdata,
    output logic                         band_data_out_valid,
    input  logic                         band_data_out_ready,
    output logic [WORD_WIDTH-1:0]        band_data_out,
    output logic                         band_data_out_last,
    output logic                         band_data_out_captured,
    input  logic                         start,
    output logic                         done,
    output logic                         idle,
    output logic                         ready
);

    localparam int DEPTH          = 2 ** BUFFER_WIDTH;
    localparam int CNT_W          = BUFFER_WIDTH + 1;
    localparam int REQ_W          = HSP_BANDS_WIDTH + HSP_LIBRARY_WIDTH;
    localparam int BANDS_PER_WORD = WORD_WIDTH / DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(WORD_WIDTH / 8);

    hsid_streamer_state_t state, state_next;

    logic [ADDR_WIDTH-1:0]        lib_addr;
    logic [HSP_LIBRARY_WIDTH-1:0] lib_size;
    logic [HSP_BANDS_WIDTH-1:0]   wpv, wpv_in, widx;
    logic [REQ_W-1:0]             req_left, lib_words;
    logic [CNT_W-1:0]             outstanding, count;
    logic                         cap_flag;
    logic                         start_ok, gnt_fire, rvalid_take, req_active;
    logic                         push, pop, tag_last;
    logic [WORD_WIDTH+1:0]        head;

    assign wpv_in    = HSP_BANDS_WIDTH'(hsid_words_per_vector(32'(hsp_bands_in), 32'(BANDS_PER_WORD)));
    assign lib_words = REQ_W'(lib_size) * REQ_W'(wpv);
    assign start_ok  = start && (state == ST_IDLE) && (outstanding == '0);

    // Requests are throttled so reserved slots (in flight + buffered) never exceed the buffer.
    assign req_active = ((state == ST_CAPTURED) || (state == ST_LIBRARY)) && (req_left != '0);
    assign mem_req    = req_active && (({1'b0, outstanding} + {1'b0, count}) < (CNT_W + 1)'(DEPTH));
    assign gnt_fire   = mem_req && mem_gnt;

    // Responses that arrive after a clear belong to the aborted job and are dropped.
    assign rvalid_take = mem_rvalid && (outstanding != '0);
    assign push        = rvalid_take && (state != ST_IDLE);
    assign pop         = band_data_out_valid && band_data_out_ready;
    assign tag_last    = (widx == (wpv - HSP_BANDS_WIDTH'(1)));

    hsid_streamer_buf #(
        .WIDTH      (WORD_WIDTH + 2),
        .ADDR_WIDTH (BUFFER_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (clear),
        .push      (push),
        .push_data ({tag_last, cap_flag, mem_rdata}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign band_data_out_valid    = (count != '0);
    assign band_data_out          = band_data_out_valid ? head[WORD_WIDTH-1:0] : '0;
    assign band_data_out_last     = band_data_out_valid && head[WORD_WIDTH+1];
    assign band_data_out_captured = band_data_out_valid && head[WORD_WIDTH];
    assign idle                   = (state == ST_IDLE);
    assign ready                  = (state == ST_IDLE) && (outstanding == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; clear overrides every transition.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_next = (hsp_bands_in == '0) ? ST_DONE : ST_CAPTURED;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_CAPTURED: begin
                if (gnt_fire && (req_left == REQ_W'(1))) begin
                    state_next = (lib_size == '0) ? ST_DRAIN : ST_LIBRARY;
                end else begin
                    state_next = ST_CAPTURED;
                end
            end
            ST_LIBRARY: begin
                if (gnt_fire && (req_left == REQ_W'(1))) begin
                    state_next = ST_DRAIN;
                end else begin
                    state_next = ST_LIBRARY;
                end
            end
            ST_DRAIN: begin
                if ((outstanding == '0) && (count == '0)) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        if (clear) begin
            state_next = ST_IDLE;
        end else begin
            state_next = state_next;
        end
    end

    // Job parameters, request address/count, in-flight tracking and word tagging.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr    <= '0;
            lib_addr    <= '0;
            lib_size    <= '0;
            wpv         <= '0;
            req_left    <= '0;
            widx        <= '0;
            cap_flag    <= 1'b0;
            outstanding <= '0;
            done        <= 1'b0;
        end else begin
            done <= (state == ST_DONE) && !clear;

            case ({gnt_fire, rvalid_take})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase

            if (start_ok && !clear) begin
                mem_addr <= captured_addr_in;
                lib_addr <= library_addr_in;
                lib_size <= hsp_library_size_in;
                wpv      <= wpv_in;
                req_left <= REQ_W'(wpv_in);
                widx     <= '0;
                cap_flag <= 1'b1;
            end else if (gnt_fire) begin
                // The last captured grant hands over directly to the library base.
                if ((state == ST_CAPTURED) && (req_left == REQ_W'(1))) begin
                    mem_addr <= lib_addr;
                    req_left <= lib_words;
                end else begin
                    mem_addr <= mem_addr + ADDR_STEP;
                    req_left <= req_left - REQ_W'(1);
                end
            end else begin
                mem_addr <= mem_addr;
            end

            if (push) begin
                if (tag_last) begin
                    widx     <= '0;
                    cap_flag <= 1'b0;
                end else begin
                    widx <= widx + HSP_BANDS_WIDTH'(1);
                end
            end
        end
    end

endmodule
